// File: rtl/player_input_conditioner.sv
// Keyboard-to-player action conditioner: synchronises and debounces raw key bits,
// then derives per-player movement levels, a latched jump request and a confirm pulse.
module player_input_conditioner #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LR_MODE         = 0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [4*NUM_PLAYERS-1:0] keycode,
    input  logic                     sample_en,
    input  logic [NUM_PLAYERS-1:0]   jump_ack,
    output logic [NUM_PLAYERS-1:0]   move_left,
    output logic [NUM_PLAYERS-1:0]   move_right,
    output logic [NUM_PLAYERS-1:0]   jump_held,
    output logic [NUM_PLAYERS-1:0]   jump_req,
    output logic                     confirm_pulse
);

    localparam int NUM_BITS    = 3 * NUM_PLAYERS + 1;
    localparam int CONFIRM_IDX = 3 * NUM_PLAYERS;
    localparam int CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    // Internal packed order: per player {jump, left, right}, confirm on top.
    localparam int RIGHT_OFS = 0;
    localparam int LEFT_OFS  = 1;
    localparam int JUMP_OFS  = 2;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [NUM_BITS-1:0]    raw_bits;
    logic [NUM_PLAYERS-1:0] unused_reserved;
    logic [NUM_BITS-1:0]    sync_meta;
    logic [NUM_BITS-1:0]    sync_bits;
    logic [NUM_BITS-1:0]    filt;
    logic [NUM_BITS-1:0]    filt_prev;
    logic [NUM_BITS-1:0]    rise;
    logic [CNT_W-1:0]       cnt [NUM_BITS];

    logic [NUM_PLAYERS-1:0] left_nxt;
    logic [NUM_PLAYERS-1:0] right_nxt;
    logic [NUM_PLAYERS-1:0] req_nxt;
    dir_t                   last_dir [NUM_PLAYERS];
    dir_t                   dir_nxt  [NUM_PLAYERS];

    // Gather the used key bits; reserved bit3 of every nibble but the top one is dropped.
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        raw_bits        = '0;
        unused_reserved = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw_bits[3*p + RIGHT_OFS] = keycode[4*(NUM_PLAYERS-1-p) + 0];
            raw_bits[3*p + LEFT_OFS]  = keycode[4*(NUM_PLAYERS-1-p) + 1];
            raw_bits[3*p + JUMP_OFS]  = keycode[4*(NUM_PLAYERS-1-p) + 2];
            if (p != 0) begin
                unused_reserved[p] = keycode[4*(NUM_PLAYERS-1-p) + 3];
            end
        end
        raw_bits[CONFIRM_IDX] = keycode[4*NUM_PLAYERS-1];
    end

    // Two-flop synchroniser, clocked every edge regardless of sample_en.
    // NOTE: non-blocking assignments let sync_bits take the old sync_meta value,
    // giving two real flop stages instead of one collapsed stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_meta <= '0;
            sync_bits <= '0;
        end else begin
            sync_meta <= raw_bits;
            sync_bits <= sync_meta;
        end
    end

    // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any
    // other state; a partial count must not survive reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt <= '0;
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt[i] <= '0;
            end
        end else if (sample_en) begin
            for (int i = 0; i < NUM_BITS; i++) begin
                if (sync_bits[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] + CNT_ONE == CNT_DONE) begin
                    filt[i] <= ~filt[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_prev <= '0;
        end else begin
            filt_prev <= filt;
        end
    end

    assign rise = filt & ~filt_prev;

    // Direction resolution and jump request next-state, one slice per player.
    always_comb begin
        left_nxt  = '0;
        right_nxt = '0;
        req_nxt   = jump_req;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir_nxt[p] = last_dir[p];
            if (rise[3*p + LEFT_OFS]) begin
                dir_nxt[p] = DIR_LEFT;
            end else if (rise[3*p + RIGHT_OFS]) begin
                dir_nxt[p] = DIR_RIGHT;
            end

            if (filt[3*p + LEFT_OFS] && !filt[3*p + RIGHT_OFS]) begin
                left_nxt[p] = 1'b1;
            end else if (!filt[3*p + LEFT_OFS] && filt[3*p + RIGHT_OFS]) begin
                right_nxt[p] = 1'b1;
            end else if (filt[3*p + LEFT_OFS] && filt[3*p + RIGHT_OFS] && (LR_MODE != 0)) begin
                left_nxt[p]  = (dir_nxt[p] == DIR_LEFT);
                right_nxt[p] = (dir_nxt[p] == DIR_RIGHT);
            end

            // A fresh press wins over a coincident acknowledge so it is never lost.
            if (rise[3*p + JUMP_OFS]) begin
                req_nxt[p] = 1'b1;
            end else if (jump_ack[p]) begin
                req_nxt[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            move_left     <= '0;
            move_right    <= '0;
            jump_held     <= '0;
            jump_req      <= '0;
            confirm_pulse <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                last_dir[p] <= DIR_LEFT;
            end
        end else begin
            move_left     <= left_nxt;
            move_right    <= right_nxt;
            jump_req      <= req_nxt;
            confirm_pulse <= rise[CONFIRM_IDX];
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                last_dir[p]  <= dir_nxt[p];
                jump_held[p] <= filt[3*p + JUMP_OFS];
            end
        end
    end

endmodule

// File: tb/tb_player_input_conditioner.sv
// Directed bench for player_input_conditioner: default, last-pressed-wins and
// three-player/sparse-sample instances checked against hand-computed values.
module tb_player_input_conditioner;

    logic        Clk;
    logic        Reset_n;
    logic [7:0]  keycode;
    logic        sample_en;
    logic [1:0]  jump_ack;

    logic [1:0]  move_left, move_right, jump_held, jump_req;
    logic        confirm_pulse;
    logic [1:0]  move_left_b, move_right_b, jump_held_b, jump_req_b;
    logic        confirm_pulse_b;

    logic [11:0] keycode3;
    logic        sample_en3;
    logic [2:0]  jump_ack3;
    logic [2:0]  move_left3, move_right3, jump_held3, jump_req3;
    logic        confirm_pulse3;

    int n_checks = 0;
    int n_errors = 0;
    int pulses3  = 0;

    player_input_conditioner #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .LR_MODE(0)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .sample_en(sample_en),
        .jump_ack(jump_ack), .move_left(move_left), .move_right(move_right),
        .jump_held(jump_held), .jump_req(jump_req), .confirm_pulse(confirm_pulse)
    );

    player_input_conditioner #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .LR_MODE(1)) dut_lr (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .sample_en(sample_en),
        .jump_ack(jump_ack), .move_left(move_left_b), .move_right(move_right_b),
        .jump_held(jump_held_b), .jump_req(jump_req_b), .confirm_pulse(confirm_pulse_b)
    );

    player_input_conditioner #(.NUM_PLAYERS(3), .DEBOUNCE_CYCLES(1), .LR_MODE(0)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode3), .sample_en(sample_en3),
        .jump_ack(jump_ack3), .move_left(move_left3), .move_right(move_right3),
        .jump_held(jump_held3), .jump_req(jump_req3), .confirm_pulse(confirm_pulse3)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Sparse strobe for the three-player instance: high one cycle in four.
    initial begin
        int phase;
        phase      = 0;
        sample_en3 = 1'b0;
        forever begin
            @(negedge Clk);
            phase      = phase + 1;
            sample_en3 = (phase % 4 == 0);
        end
    end

    typedef struct {
        string      name;
        logic [7:0] key;
        logic [1:0] ack;
        int         cycles;
        logic [1:0] exp_left;
        logic [1:0] exp_right;
        logic [1:0] exp_held;
        logic [1:0] exp_req;
        logic [1:0] exp_left_b;
        logic [1:0] exp_right_b;
    } vec_t;

    localparam int NUM_VECS = 22;
    vec_t vecs [NUM_VECS];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic phase3(input logic [11:0] key, input logic [2:0] ack, input int n);
        keycode3  = key;
        jump_ack3 = ack;
        pulses3   = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            jump_ack3 = '0;
            if (confirm_pulse3) pulses3++;
        end
    endtask

    initial begin
        int pulses, pulses_b, first_at;
        logic seen;

        //                name                key    ack    cyc  L      R      H      Q      Lb     Rb
        vecs[0]  = '{"idle0",            8'h00, 2'b00, 8,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{"p1_left_early",    8'h02, 2'b00, 6,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{"p1_left",          8'h02, 2'b00, 1,  2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        vecs[3]  = '{"p1_both",          8'h03, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        vecs[4]  = '{"p1_rel_right",     8'h02, 2'b00, 10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
        vecs[5]  = '{"idle1",            8'h00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{"p0_right",         8'h10, 2'b00, 10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[7]  = '{"p0_add_left",      8'h30, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[8]  = '{"p0_rel_right",     8'h20, 2'b00, 10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[9]  = '{"p0_repress_right", 8'h30, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        vecs[10] = '{"idle2",            8'h00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[11] = '{"p0_both_simul",    8'h30, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        vecs[12] = '{"idle3",            8'h00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{"p0_jump",          8'h40, 2'b00, 10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[14] = '{"p0_ack",           8'h40, 2'b01, 10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{"p0_jump_rel",      8'h00, 2'b00, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[16] = '{"both_jump",        8'h44, 2'b00, 10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
        vecs[17] = '{"p1_ack",           8'h44, 2'b10, 10, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
        vecs[18] = '{"ack_release",      8'h00, 2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[19] = '{"ack_idle",         8'h00, 2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[20] = '{"jump_left",        8'h66, 2'b00, 10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00};
        vecs[21] = '{"release_ack",      8'h00, 2'b11, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

        // Reset with every key pressed: all outputs low.
        Reset_n   = 1'b0;
        keycode   = 8'hFF;
        keycode3  = 12'hFFF;
        sample_en = 1'b1;
        jump_ack  = '0;
        jump_ack3 = '0;
        repeat (3) tick();
        check("rst_left",     {move_left, move_left_b, move_left3},     '0);
        check("rst_right",    {move_right, move_right_b, move_right3},  '0);
        check("rst_held",     {jump_held, jump_held_b, jump_held3},     '0);
        check("rst_req",      {jump_req, jump_req_b, jump_req3},        '0);
        check("rst_confirm",  {confirm_pulse, confirm_pulse_b, confirm_pulse3}, '0);

        // Jump held through release: request after edge 6, no confirm.
        @(negedge Clk);
        Reset_n  = 1'b1;
        keycode  = 8'h40;
        keycode3 = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("post_rst_req_%0d", i),  jump_req,  (i >= 6) ? 2'b01 : 2'b00);
            check($sformatf("post_rst_held_%0d", i), jump_held, (i >= 6) ? 2'b01 : 2'b00);
            check($sformatf("post_rst_conf_%0d", i), confirm_pulse, 1'b0);
        end
        keycode  = 8'h00;
        jump_ack = 2'b01;
        tick();
        jump_ack = '0;
        check("post_rst_ack", jump_req, 2'b00);
        repeat (10) tick();

        // Glitch of three samples is rejected.
        seen    = 1'b0;
        keycode = 8'h10;
        repeat (3) tick();
        keycode = 8'h00;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (move_right[0] || move_right_b[0]) seen = 1'b1;
        end
        check("glitch_no_right", seen, 1'b0);

        // Sustained press: exact six-edge latency.
        keycode = 8'h10;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("right_lat_%0d", i), move_right, (i >= 6) ? 2'b01 : 2'b00);
        end
        keycode = 8'h00;
        repeat (10) tick();

        // Confirm held for 100 cycles: exactly one pulse, at index 6.
        pulses   = 0;
        pulses_b = 0;
        first_at = -1;
        keycode  = 8'h80;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (confirm_pulse) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            if (confirm_pulse_b) pulses_b++;
        end
        check("confirm_count",   pulses,   1);
        check("confirm_at",      first_at, 6);
        check("confirm_count_b", pulses_b, 1);
        pulses  = 0;
        keycode = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (confirm_pulse) pulses++;
        end
        check("confirm_release", pulses, 0);

        // Steady-state vector table.
        for (int i = 0; i < NUM_VECS; i++) begin
            keycode  = vecs[i].key;
            jump_ack = vecs[i].ack;
            tick();
            jump_ack = '0;
            repeat (vecs[i].cycles - 1) tick();
            check($sformatf("%s.left", vecs[i].name),    move_left,    vecs[i].exp_left);
            check($sformatf("%s.right", vecs[i].name),   move_right,   vecs[i].exp_right);
            check($sformatf("%s.held", vecs[i].name),    jump_held,    vecs[i].exp_held);
            check($sformatf("%s.req", vecs[i].name),     jump_req,     vecs[i].exp_req);
            check($sformatf("%s.left_b", vecs[i].name),  move_left_b,  vecs[i].exp_left_b);
            check($sformatf("%s.right_b", vecs[i].name), move_right_b, vecs[i].exp_right_b);
            check($sformatf("%s.held_b", vecs[i].name),  jump_held_b,  vecs[i].exp_held);
            check($sformatf("%s.req_b", vecs[i].name),   jump_req_b,   vecs[i].exp_req);
        end

        // Jump handshake corner cases.
        keycode = 8'h40;
        repeat (10) tick();
        check("hs_req_set", jump_req, 2'b01);
        jump_ack = 2'b01;
        tick();
        jump_ack = '0;
        check("hs_ack_next", jump_req, 2'b00);
        repeat (10) tick();
        check("hs_no_rearm", jump_req, 2'b00);
        check("hs_still_held", jump_held, 2'b01);
        keycode = 8'h00;
        repeat (10) tick();
        keycode = 8'h40;
        repeat (10) tick();
        check("hs_repress", jump_req, 2'b01);
        keycode = 8'h00;
        repeat (10) tick();
        check("hs_req_survives_release", jump_req, 2'b01);
        keycode = 8'h40;
        repeat (6) tick();
        jump_ack = 2'b01;
        tick();
        jump_ack = '0;
        check("hs_ack_on_rise", jump_req, 2'b01);
        repeat (3) tick();
        check("hs_ack_on_rise_hold", jump_req, 2'b01);

        // Three-player instance with DEBOUNCE_CYCLES=1 and sparse sampling.
        phase3(12'h004, 3'b000, 16);
        check("p3_jump_held", jump_held3, 3'b100);
        check("p3_jump_req",  jump_req3,  3'b100);
        check("p3_jump_move", {move_left3, move_right3}, 6'b0);
        phase3(12'h000, 3'b000, 16);
        check("p3_req_kept",  jump_req3,  3'b100);
        check("p3_held_rel",  jump_held3, 3'b000);
        phase3(12'h000, 3'b100, 16);
        check("p3_req_acked", jump_req3,  3'b000);
        phase3(12'h003, 3'b000, 16);
        check("p3_both_left",  move_left3,  3'b000);
        check("p3_both_right", move_right3, 3'b000);
        phase3(12'h002, 3'b000, 16);
        check("p3_left", move_left3, 3'b100);
        phase3(12'h010, 3'b000, 16);
        check("p3_p1_right", move_right3, 3'b010);
        check("p3_p1_left",  move_left3,  3'b000);
        phase3(12'h400, 3'b000, 16);
        check("p3_p0_req",  jump_req3,  3'b001);
        check("p3_p0_held", jump_held3, 3'b001);
        phase3(12'h008, 3'b001, 16);
        check("p3_reserved_outs", {move_left3, move_right3, jump_held3, jump_req3}, 12'h000);
        check("p3_reserved_conf", pulses3, 0);
        phase3(12'h800, 3'b000, 16);
        check("p3_confirm", pulses3, 1);
        check("p3_confirm_outs", {move_left3, move_right3, jump_held3}, 9'h000);
        phase3(12'h000, 3'b000, 16);
        phase3(12'h004, 3'b000, 16);
        check("p3_pre_rst_req", jump_req3, 3'b100);

        // Reset in the middle of a pending press.
        keycode3 = 12'h001;
        repeat (2) tick();
        Reset_n = 1'b0;
        #1;
        check("mid_rst_req3",  jump_req3,  3'b000);
        check("mid_rst_held3", jump_held3, 3'b000);
        check("mid_rst_req",   jump_req,   2'b00);
        check("mid_rst_held",  jump_held,  2'b00);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_rst_quiet_%0d", i), {move_right3, jump_req3}, 6'b0);
        end
        repeat (16) tick();
        check("mid_rst_right3", move_right3, 3'b100);
        check("mid_rst_req3_after", jump_req3, 3'b000);
        check("mid_rst_fresh_req", jump_req, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/player_input_conditioner.md
# player_input_conditioner

Parametrised keyboard-to-player action conditioner. It sits between the keycode register written by the USB/NIOS keyboard path and the per-player physics/menu logic, replacing a pure bit-slicing decode. Per key bit it adds:
- synchronisation and debounce
- left/right conflict resolution
- a latched jump request with acknowledge handshake
- a single-cycle menu confirm pulse

## Interface
Parameters:
- NUM_PLAYERS, 2, number of characters served (≥1).
- DEBOUNCE_CYCLES, 4, consecutive qualifying samples a raw bit must differ from its filtered level before the filtered level flips (≥1).
- LR_MODE, 0, 0 = opposing left+right cancel (neither output), 1 = last-pressed direction wins.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  4*NUM_PLAYERS  raw key bits, asynchronous to Clk. Player p occupies nibble [4*(NUM_PLAYERS-1-p) +: 4]. Within a nibble: bit2 jump, bit1 left, bit0 right, bit3 reserved. Exception: bit3 of the top nibble (keycode MSB) is confirm. For NUM_PLAYERS=2: player0 = bits 6:4, player1 = bits 2:0, confirm = bit 7, bit 3 ignored.
- sample_en  in  1  debounce sample strobe (e.g. 1 kHz tick); counters advance only when high.
- jump_ack  in  NUM_PLAYERS  per-player acknowledge from physics.
- move_left  out  NUM_PLAYERS  resolved left level.
- move_right  out  NUM_PLAYERS  resolved right level.
- jump_held  out  NUM_PLAYERS  debounced jump level.
- jump_req  out  NUM_PLAYERS  latched jump request, held until acknowledged.
- confirm_pulse  out  1  one-cycle pulse on debounced confirm press.

## Operation
- **Synchroniser:** every used keycode bit passes through a 2-flop synchroniser clocked every Clk edge, independent of sample_en. Reserved bits are not synchronised and have no effect.
- **Debounce:** one counter per used bit, width $clog2(DEBOUNCE_CYCLES+1).
  - On an edge with sample_en=1 and sync≠filtered: counter+1.
  - When the counter would reach DEBOUNCE_CYCLES: filtered flips and the counter clears on that same edge.
  - On an edge with sample_en=1 and sync==filtered: counter clears.
  - sample_en=0: counter and filtered hold.
- **Rising-edge detect:** a one-cycle rise strobe per filtered bit (filtered=1 and previous filtered=0).
- **Direction resolution, per player** (L/R = filtered left/right):
  - Only L → move_left=1. Only R → move_right=1. Neither → both 0.
  - Both held, LR_MODE=0 → both 0.
  - Both held, LR_MODE=1 → output follows last_dir.
  - last_dir updates on the rise of L (→left) or R (→right). Simultaneous rises → left.
  - Outputs are registered from the filtered values.
- **Jump:**
  - jump_held = filtered jump.
  - jump_req sets on the jump rise and clears on jump_ack.
  - Rise and ack on the same edge → jump_req stays 1, so the new press is not lost.
  - Ack while jump_req=0 has no effect.
  - Holding jump never re-arms the request; a release and re-press is required.
- **Confirm:** confirm_pulse = 1 for exactly one cycle per filtered confirm rise. It is not gated by any handshake.
- **Reset** (asynchronous, Reset_n=0): all outputs 0; synchronisers, filtered levels, counters and rise history 0; last_dir = left. Reset mid-debounce discards the partial count. A key held through reset release reports as a fresh press after the normal latency.

## Timing
- Press latency with sample_en tied high: key asserted before edge 0 → synchroniser output valid after edge 1 → filtered flips at edge 1+DEBOUNCE_CYCLES.
  - jump_req, confirm_pulse and move_* are visible after edge 2+DEBOUNCE_CYCLES.
  - Default parameters: 6 cycles.
- Release latency: identical, symmetric.
- With sparse sample_en, latency is 2 Clk edges plus DEBOUNCE_CYCLES qualifying sample edges, plus one output register edge.
- A glitch shorter than DEBOUNCE_CYCLES samples never changes any output.
- jump_ack is sampled on the same edge it is asserted; jump_req drops on the following cycle.

## Test plan
- **Reset/idle:** Reset_n=0 with keycode=8'hFF → all outputs 0. Release reset, sample_en=1, keycode held at 8'h40 → jump_req[0]=1 and jump_held[0]=1 six cycles after release; confirm_pulse stays 0.
- **Glitch reject:** keycode bit4 high for 3 cycles, then low, with DEBOUNCE_CYCLES=4 → move_right[0] never asserts. Hold it 4+ cycles → move_right[0]=1 after 6 cycles.
- **Opposing keys:** player1 presses left (8'h02), then right 10 cycles later (8'h03).
  - LR_MODE=0 → move_left[1] drops to 0 and move_right[1] stays 0.
  - LR_MODE=1 → move_right[1]=1 and move_left[1]=0.
  - Release right → move_left[1]=1.
- **Jump handshake:** press and hold jump[0] → jump_req[0]=1. Pulse jump_ack[0] → jump_req[0]=0 the next cycle, and stays 0 while jump is held. Release and re-press → request again. Ack on the same edge as a new rise → jump_req[0] remains 1.
- **Confirm:** hold 8'h80 for 100 cycles → exactly one confirm_pulse cycle, at cycle 6.
- **Parametrisation:** NUM_PLAYERS=3, DEBOUNCE_CYCLES=1, sample_en every 4th cycle → player2 nibble [3:0] decodes correctly, and bit 11 is confirm. Assert Reset_n mid-count → no output change afterward until a full re-debounce.
